mutex_rule_scheduler: RTL

Rule scheduler for the generated mutual-exclusion `system` datapath. It mirrors the per-node protocol state (I/T/C/E) and the shared flag `x`, and evaluates every node's rule guard. On each accepted step it picks one enabled node round-robin and emits a one-hot rule-enable vector in the same format as `io_en_a`. It sits between the stimulus/driver side and `system`, replacing free-running `io_en_a` drive so that only guard-true rules fire. It also flags stalls and mutex violations.

---
 rtl/mutex_rule_scheduler_pkg.sv | 30 +++
 rtl/mutex_rule_scheduler_rr_pick.sv | 26 ++
 rtl/mutex_rule_scheduler.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mutex_rule_scheduler_pkg.sv
// Shared encodings for the mutual-exclusion rule scheduler: node states,
// rule codes and the mapping from a node's current state to the rule it fires.
package mutex_rule_scheduler_pkg;

    typedef logic [1:0] node_state_t;
    typedef logic [1:0] rule_t;

    localparam node_state_t ST_I = 2'd0;
    localparam node_state_t ST_T = 2'd1;
    localparam node_state_t ST_C = 2'd2;
    localparam node_state_t ST_E = 2'd3;

    localparam rule_t RULE_TRY  = 2'd0;
    localparam rule_t RULE_CRIT = 2'd1;
    localparam rule_t RULE_EXIT = 2'd2;
    localparam rule_t RULE_IDLE = 2'd3;

    // Each state has exactly one outgoing rule.
    function automatic rule_t rule_of(input node_state_t s);
        rule_t r;
        case (s)
            ST_I:    r = RULE_TRY;
            ST_T:    r = RULE_CRIT;
            ST_C:    r = RULE_EXIT;
            default: r = RULE_IDLE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mutex_rule_scheduler_rr_pick.sv
// Combinational round-robin selector: grants the first requester found
// scanning upward from the node after i_ptr, wrapping modulo NODES.
module rr_pick
    import mutex_rule_scheduler_pkg::*;
#(
    parameter int NODES = 3,
    parameter int PW    = (NODES > 1) ? $clog2(NODES) : 1
) (
    input  logic [NODES-1:0] i_req,
    input  logic [PW-1:0]    i_ptr,
    output logic [NODES-1:0] o_grant,
    output logic             o_none
);

    always_comb begin
        o_grant = '0;
        o_none  = 1'b1;
        for (int off = 1; off <= NODES; off++) begin
            if (o_none && i_req[(int'(i_ptr) + off) % NODES]) begin
                o_grant[(int'(i_ptr) + off) % NODES] = 1'b1;
                o_none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mutex_rule_scheduler.sv
// Rule scheduler for the mutex system: mirrors node state and x, fires one
// guard-true rule per accepted step round-robin, and flags stalls/violations.
module mutex_rule_scheduler
    import mutex_rule_scheduler_pkg::*;
#(
    parameter int NODES     = 3,
    parameter int STALL_MAX = 15
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               step_valid,
    output logic               step_ready,
    input  logic [NODES-1:0]   hold_mask,
    output logic               fire_valid,
    output logic [NODES-1:0]   fire_en,
    output logic [1:0]         fire_rule,
    output logic [2*NODES-1:0] node_state,
    output logic               x_flag,
    output logic               deadlock,
    output logic               mutex_err
);

    localparam int PW = (NODES > 1) ? $clog2(NODES) : 1;
    localparam int CW = $clog2(STALL_MAX + 1);

    node_state_t      r_state [NODES];
    logic             r_x;
    logic [PW-1:0]    r_ptr;
    logic [CW-1:0]    r_cnt;
    logic             r_fire_valid;
    logic [NODES-1:0] r_fire_en;
    rule_t            r_fire_rule;
    logic             r_deadlock;
    logic             r_mutex_err;

    logic [NODES-1:0] w_req;
    logic [NODES-1:0] w_grant;
    logic             w_none;
    logic             w_accept;
    logic             w_fire;
    node_state_t      w_sel_state;
    logic [PW-1:0]    w_sel_idx;
    logic [CW-1:0]    w_cnt_nxt;
    logic             w_viol;
    logic             w_seen_c;

    // Only T has a data-dependent guard; everything else is gated by the hold mask.
    always_comb begin
        w_req = '0;
        for (int i = 0; i < NODES; i++) begin
            w_req[i] = !hold_mask[i] && ((r_state[i] != ST_T) || r_x);
        end
    end

    rr_pick #(
        .NODES (NODES),
        .PW    (PW)
    ) u_rr_pick (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_none  (w_none)
    );

    assign w_accept  = step_valid && !r_deadlock;
    assign w_fire    = w_accept && !w_none;
    assign w_cnt_nxt = (r_cnt == CW'(STALL_MAX)) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_sel_state = ST_I;
        w_sel_idx   = '0;
        for (int i = 0; i < NODES; i++) begin
            if (w_grant[i]) begin
                w_sel_state = r_state[i];
                w_sel_idx   = PW'(i);
            end
        end
    end

    // Invariant: at most one node in C, and none in C while x is still set.
    always_comb begin
        w_viol   = 1'b0;
        w_seen_c = 1'b0;
        for (int i = 0; i < NODES; i++) begin
            if (r_state[i] == ST_C) begin
                if (w_seen_c) w_viol = 1'b1;
                w_seen_c = 1'b1;
            end
        end
        if (w_seen_c && r_x) w_viol = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NODES; i++) r_state[i] <= ST_I;
            r_x          <= 1'b1;
            r_ptr        <= PW'(NODES - 1);
            r_cnt        <= '0;
            r_fire_valid <= 1'b0;
            r_fire_en    <= '0;
            r_fire_rule  <= RULE_TRY;
            r_deadlock   <= 1'b0;
            r_mutex_err  <= 1'b0;
        end else begin
            r_fire_valid <= w_fire;
            r_fire_en    <= w_fire ? w_grant : '0;
            r_fire_rule  <= w_fire ? rule_of(w_sel_state) : RULE_TRY;
            r_mutex_err  <= r_mutex_err | w_viol;
            if (w_fire) begin
                // State codes are ordered I,T,C,E so every rule is a +1 with wrap.
                for (int i = 0; i < NODES; i++) begin
                    if (w_grant[i]) r_state[i] <= node_state_t'(r_state[i] + 2'd1);
                end
                if (w_sel_state == ST_T)      r_x <= 1'b0;
                else if (w_sel_state == ST_E) r_x <= 1'b1;
                r_ptr <= w_sel_idx;
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt <= w_cnt_nxt;
                if (w_cnt_nxt == CW'(STALL_MAX)) r_deadlock <= 1'b1;
            end
        end
    end

    always_comb begin
        node_state = '0;
        for (int i = 0; i < NODES; i++) node_state[2*i +: 2] = r_state[i];
    end

    assign step_ready = !r_deadlock;
    assign fire_valid = r_fire_valid;
    assign fire_en    = r_fire_en;
    assign fire_rule  = r_fire_rule;
    assign x_flag     = r_x;
    assign deadlock   = r_deadlock;
    assign mutex_err  = r_mutex_err;

endmodule
